// File: rtl/cw_trig_capture.sv
// Trigger-and-capture engine for the on-chip signal watcher.
// Probe buses are registered twice (s1 = current, s2 = previous). Each bus is
// compared according to its own mode, the per-bus results are combined by
// AND or OR, and a small FSM streams samples into a circular sample RAM.
// The FSM keeps pc samples before the trigger and DEPTH-1-pc samples after it.
//
// Handshake: this block has no valid/ready pairs. arm and abort are single-cycle
// pulses sampled on trig_clk; abort wins over arm. A RAM write happens in every
// cycle where wt_en is high, at wt_addr with wt_data.
module cw_trig_capture #(
  parameter int BUS_NUM   = 2,
  parameter int BUS_WIDTH = 10,
  parameter int ADDR_W    = 10
) (
  input  logic                           trig_clk,
  input  logic                           jrstn,
  input  logic                           arm,
  input  logic                           abort,
  input  logic [BUS_NUM*BUS_WIDTH-1:0]   bus_din,
  input  logic [BUS_NUM*BUS_WIDTH-1:0]   cmp_val,
  input  logic [BUS_NUM*BUS_WIDTH-1:0]   cmp_mask,
  input  logic [BUS_NUM*3-1:0]           cmp_mode,
  input  logic                           comb_or,
  input  logic [ADDR_W-1:0]              pre_cnt,
  output logic                           wt_ce,
  output logic                           wt_en,
  output logic [ADDR_W-1:0]              wt_addr,
  output logic [BUS_NUM*BUS_WIDTH-1:0]   wt_data,
  output logic [ADDR_W-1:0]              trig_addr,
  output logic                           triggered,
  output logic                           busy,
  output logic                           done
);

  localparam int DW = BUS_NUM * BUS_WIDTH;
  localparam logic [ADDR_W-1:0] LAST = '1;   // DEPTH-1
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  // State is kept in a named register so checkers can bind to it directly.
  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;
  state_t state;

  logic [DW-1:0]      s1;
  logic [DW-1:0]      s2;
  logic [ADDR_W-1:0]  addr;
  logic [ADDR_W-1:0]  post;
  logic               first_smp;   // s2 does not yet hold a sample from this capture
  logic [BUS_NUM-1:0] bus_hit;
  logic               trig_hit;
  logic               writing;

  // pre_cnt is ADDR_W bits wide, so it can never exceed DEPTH-1; the clamp
  // min(pre_cnt, DEPTH-1) is therefore the value itself.

  for (genvar k = 0; k < BUS_NUM; k++) begin : g_bus
    logic [BUS_WIDTH-1:0] cur;
    logic [BUS_WIDTH-1:0] prev;
    logic [BUS_WIDTH-1:0] val;
    logic [BUS_WIDTH-1:0] msk;
    logic                 eq_cur;
    logic                 eq_prev;
    logic                 chg;
    logic                 hit;

    assign cur     = s1[k*BUS_WIDTH +: BUS_WIDTH];
    assign prev    = s2[k*BUS_WIDTH +: BUS_WIDTH];
    assign val     = cmp_val[k*BUS_WIDTH +: BUS_WIDTH];
    assign msk     = cmp_mask[k*BUS_WIDTH +: BUS_WIDTH];
    assign eq_cur  = ((cur ^ val) & msk) == '0;
    assign eq_prev = ((prev ^ val) & msk) == '0;
    assign chg     = ((cur ^ prev) & msk) != '0;

    // Per-bus match; history-based modes are suppressed until a previous sample exists.
    always_comb begin
      hit = 1'b0;
      case (cmp_mode[k*3 +: 3])
        3'd0:    hit = eq_cur;
        3'd1:    hit = !eq_cur;
        3'd2:    hit = !first_smp && eq_cur && !eq_prev;
        3'd3:    hit = !first_smp && chg;
        3'd4:    hit = !comb_or;
        default: hit = 1'b0;
      endcase
    end

    assign bus_hit[k] = hit;
  end

  assign trig_hit = comb_or ? (|bus_hit) : (&bus_hit);
  assign writing  = (state == PRE) || (state == WAIT) || (state == POST);

  // Probe pipeline, RAM write port and capture FSM.
  always_ff @(posedge trig_clk or negedge jrstn) begin
    if (!jrstn) begin
      state     <= IDLE;
      s1        <= '0;
      s2        <= '0;
      addr      <= '0;
      post      <= '0;
      first_smp <= 1'b0;
      wt_ce     <= 1'b0;
      wt_en     <= 1'b0;
      wt_addr   <= '0;
      wt_data   <= '0;
      trig_addr <= '0;
      triggered <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      s1    <= bus_din;
      s2    <= s1;
      wt_ce <= 1'b0;
      wt_en <= 1'b0;

      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        triggered <= 1'b0;
        done      <= 1'b0;
      end else begin
        if (writing) begin
          wt_ce     <= 1'b1;
          wt_en     <= 1'b1;
          wt_addr   <= addr;
          wt_data   <= s1;
          addr      <= addr + ONE;
          first_smp <= 1'b0;
        end

        case (state)
          IDLE, DONE: begin
            if (arm) begin
              addr      <= '0;
              triggered <= 1'b0;
              done      <= 1'b0;
              busy      <= 1'b1;
              first_smp <= 1'b1;
              state     <= (pre_cnt != '0) ? PRE : WAIT;
            end
          end
          PRE: begin
            if (addr == pre_cnt - ONE) state <= WAIT;
          end
          WAIT: begin
            if (trig_hit) begin
              trig_addr <= addr;
              triggered <= 1'b1;
              post      <= LAST - pre_cnt;
              if (pre_cnt == LAST) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= POST;
              end
            end
          end
          POST: begin
            post <= post - ONE;
            if (post == ONE) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/cw_trig_capture.md
Name: cw_trig_capture

Overview:
- Parametrised trigger-and-capture engine for the on-chip signal watcher.
- Supersedes the fixed single-bus, equality-only capture unit. It supports:
  - N probe buses, each with its own compare mode.
  - AND/OR trigger combining.
  - A programmable pre-trigger window.
  - A circular sample-RAM write port.
- Sits in the trig_clk domain between the probed design nets and the sample RAM. Static configuration comes from the JTAG control-register shadow, already synchronised.

Parameters:
- BUS_NUM, 2, number of probe buses.
- BUS_WIDTH, 10, bits per probe bus; all buses are this width.
- ADDR_W, 10, sample-RAM address width; DEPTH = 2**ADDR_W.

Ports:
- trig_clk  in  1  sample clock.
- jrstn  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle start pulse.
- abort  in  1  one-cycle cancel pulse.
- bus_din  in  BUS_NUM*BUS_WIDTH  probed nets; bus k occupies bits [k*BUS_WIDTH +: BUS_WIDTH].
- cmp_val  in  BUS_NUM*BUS_WIDTH  per-bus compare value.
- cmp_mask  in  BUS_NUM*BUS_WIDTH  per-bus compare mask; 1 = bit participates.
- cmp_mode  in  BUS_NUM*3  per-bus mode.
- comb_or  in  1  0 = AND of bus matches, 1 = OR.
- pre_cnt  in  ADDR_W  pre-trigger sample count.
- wt_ce  out  1  RAM chip enable.
- wt_en  out  1  RAM write enable.
- wt_addr  out  ADDR_W  RAM write address.
- wt_data  out  BUS_NUM*BUS_WIDTH  RAM write data.
- trig_addr  out  ADDR_W  address of the trigger sample.
- triggered  out  1  trigger has fired.
- busy  out  1  capture in progress.
- done  out  1  capture complete.

Behaviour:
- Reset (jrstn low, async): all outputs 0, internal pipeline 0, state IDLE.
- Pipeline:
  - s1 <= bus_din; s2 <= s1.
  - Match is evaluated on s1 (current) against s2 (previous).
  - wt_data <= s1, registered together with wt_en and wt_addr. bus_din at cycle N is therefore written at cycle N+2.
  - The sample that fires the trigger is the one written at trig_addr.
- Per-bus match, with m = cmp_mask:
  - mode 0: equal, (s1&m)==(cmp_val&m).
  - mode 1: not-equal.
  - mode 2: enter-match; current sample equal and previous not equal.
  - mode 3: change, (s1^s2)&m != 0.
  - mode 4: don't-care; true in AND, false in OR.
  - modes 5-7: disabled, always false.
  - Modes 2 and 3 are false on the first sample after arm, because there is no valid previous sample.
- Combine: trig_hit = AND or OR over buses, selected by comb_or.
- pc = min(pre_cnt, DEPTH-1).
- States:
  - IDLE: wt_ce=0, wt_en=0. On arm: addr<=0, triggered<=0, done<=0; go to PRE if pc>0, else WAIT.
  - PRE: write each cycle, addr++ (wraps at DEPTH-1). After pc writes, go to WAIT. trig_hit is ignored in PRE.
  - WAIT: write each cycle, circular overwrite allowed. On trig_hit:
    - trig_addr<=addr, triggered<=1, post<=DEPTH-1-pc.
    - If post is 0, go to DONE after this write; otherwise go to POST.
  - POST: write each cycle, post--. After the last write, go to DONE.
  - DONE: wt_ce=0, wt_en=0, done=1. Hold until arm (restart) or abort (to IDLE).
- Outputs per state:
  - busy = 1 in PRE, WAIT and POST.
  - wt_ce = busy, registered, aligned with wt_en.
- Capture result: the final buffer holds exactly DEPTH samples, with pc samples before trig_addr and DEPTH-1-pc after it.
- Boundaries:
  - arm while busy is ignored.
  - abort in any state: to IDLE next cycle, wt_en deasserted, triggered<=0, done<=0, trig_addr held.
  - abort and arm in the same cycle: abort wins.
  - Address wraps DEPTH-1 -> 0 with no gap.
  - Configuration inputs must be static while busy; they are sampled every cycle and are not latched.
  - jrstn asserted mid-capture: immediate IDLE, no further writes.

Test Plan:
- BUS_NUM=2, ADDR_W=4, pre_cnt=4, bus0 mode0 cmp=0x155 mask=0x3FF, bus1 mode4, AND; arm at t0, match sample becomes the 8th write -> PRE writes addr 0-3, trig_addr=7, 11 post writes addr 8..15,0,1,2, done=1 after the addr-2 write, busy=0.
- pre_cnt=0, ADDR_W=4, immediate match -> trig_addr=0, 15 post writes addr 1..15, done.
- pre_cnt=15 (DEPTH-1) -> PRE writes 0..14, trigger at addr 15, no POST, done next cycle.
- bus0 mode3 mask=0x001, OR with bus1 mode5; bus_din constant, then bit0 toggles -> trigger on the toggle sample only, never on the first sample after arm.
- Abort during POST -> busy=0, wt_en=0 next cycle, triggered=0; a subsequent arm restarts at addr 0.
- Arm during WAIT ignored; jrstn pulsed mid-WAIT -> all outputs 0, no writes until the next arm.
